// File: rtl/packet_buffer_read_arbiter_if.sv
// packet_buffer_read_arbiter_if: lane-side FIFO read ports and output stream of the packet buffer read arbiter.
interface packet_buffer_read_arbiter_if #(
    parameter int NUM_LANES             = 4,
    parameter int AXI_WIDTH             = 64,
    parameter int LANE_SELECT_IDX_WIDTH = 2
);
    logic                             lane_valid_i [NUM_LANES];
    logic [AXI_WIDTH-1:0]             lane_data_i  [NUM_LANES];
    logic                             lane_last_i  [NUM_LANES];
    logic                             lane_ready_o [NUM_LANES];
    logic                             out_valid_o;
    logic [AXI_WIDTH-1:0]             out_data_o;
    logic                             out_last_o;
    logic [LANE_SELECT_IDX_WIDTH-1:0] out_lane_o;
    logic                             out_ready_i;
    logic                             err_o;

    modport master (
        input  lane_valid_i, lane_data_i, lane_last_i, out_ready_i,
        output lane_ready_o, out_valid_o, out_data_o, out_last_o, out_lane_o, err_o
    );

    modport slave (
        output lane_valid_i, lane_data_i, lane_last_i, out_ready_i,
        input  lane_ready_o, out_valid_o, out_data_o, out_last_o, out_lane_o, err_o
    );
endinterface

// File: rtl/packet_buffer_read_arbiter.sv
// packet_buffer_read_arbiter: packet-atomic round-robin arbiter over per-lane FIFOs with a registered output stage.
// Optional overlength check compiled in with PACKET_BUFFER_READ_ARB_LEN_CHECK_EN.
module packet_buffer_read_arbiter #(
    parameter int NUM_LANES             = 4,
    parameter int AXI_WIDTH             = 64,
    parameter int LANE_SELECT_IDX_WIDTH = 2,
    parameter int MAX_PACKET_BEATS      = 192
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    packet_buffer_read_arbiter_if.master bus
);
    localparam int IW = LANE_SELECT_IDX_WIDTH;

    typedef enum logic {IDLE, XFER} state_t;

    if (IW < $clog2(NUM_LANES) || MAX_PACKET_BEATS < 1) begin : g_bad_cfg
        $error("packet_buffer_read_arbiter: invalid lane index width or packet length limit");
    end

    state_t               state_q, state_d;
    logic [IW-1:0]        grant_q, grant_d, last_grant_q, last_grant_d, pick;
    logic                 out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [AXI_WIDTH-1:0] out_data_q, out_data_d;
    logic [IW-1:0]        out_lane_q, out_lane_d;
    logic                 load_en, found, accept, beat_last, end_pkt;

    assign load_en   = !out_valid_q || bus.out_ready_i;
    assign accept    = state_q == XFER && bus.lane_valid_i[grant_q] && load_en;
    assign beat_last = bus.lane_last_i[grant_q];

`ifdef PACKET_BUFFER_READ_ARB_LEN_CHECK_EN
    localparam int CW = $clog2(MAX_PACKET_BEATS + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d, overlong;

    // The limit-th beat without last closes the packet; the remainder re-arbitrates as a new packet.
    assign overlong = accept && !beat_last && cnt_q == CW'(MAX_PACKET_BEATS - 1);
    assign end_pkt  = accept && (beat_last || overlong);
    assign cnt_d    = state_q == IDLE ? '0 : (accept ? cnt_q + CW'(1) : cnt_q);
    assign err_d    = err_q || overlong;
    assign bus.err_o = err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`else
    assign end_pkt   = accept && beat_last;
    assign bus.err_o = 1'b0;
`endif

    // Rotating search starting just after the last lane that completed a packet.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = 1; i <= NUM_LANES; i++) begin
            if (!found && bus.lane_valid_i[(int'(last_grant_q) + i) % NUM_LANES]) begin
                found = 1'b1;
                pick  = IW'((int'(last_grant_q) + i) % NUM_LANES);
            end
        end
    end

    always_comb begin
        for (int l = 0; l < NUM_LANES; l++)
            bus.lane_ready_o[l] = state_q == XFER && grant_q == IW'(l) && load_en;
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        if (state_q == IDLE && found) begin
            state_d = XFER;
            grant_d = pick;
        end
        if (end_pkt) begin
            state_d      = IDLE;
            last_grant_d = grant_q;
        end
        out_valid_d = accept ? 1'b1 : (bus.out_ready_i ? 1'b0 : out_valid_q);
        out_data_d  = accept ? bus.lane_data_i[grant_q] : out_data_q;
        out_last_d  = accept ? end_pkt : out_last_q;
        out_lane_d  = accept ? grant_q : out_lane_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= IW'(NUM_LANES - 1);
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            out_lane_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            out_lane_q   <= out_lane_d;
        end
    end

    assign bus.out_valid_o = out_valid_q;
    assign bus.out_data_o  = out_data_q;
    assign bus.out_last_o  = out_last_q;
    assign bus.out_lane_o  = out_lane_q;
endmodule

// File: tb/tb_packet_buffer_read_arbiter.sv
// tb_packet_buffer_read_arbiter: directed checks of packet-atomic round-robin arbitration and output stalls.
module tb_packet_buffer_read_arbiter;
`ifdef PACKET_BUFFER_READ_ARB_LEN_CHECK_EN
    localparam int MAXB = 4;
`else
    localparam int MAXB = 192;
`endif

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    packet_buffer_read_arbiter_if #(.NUM_LANES(4), .AXI_WIDTH(64), .LANE_SELECT_IDX_WIDTH(2)) bus ();

    packet_buffer_read_arbiter #(
        .NUM_LANES(4), .AXI_WIDTH(64), .LANE_SELECT_IDX_WIDTH(2), .MAX_PACKET_BEATS(MAXB)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus  (bus)
    );

    logic [64:0] q [4][$];
    logic        hold [4];
    logic [63:0] log_data [$];
    logic        log_last [$];
    int          log_lane [$];
    int          log_cyc  [$];
    int          cyc, n_vec, n_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] rdy();
        logic [3:0] r;
        for (int l = 0; l < 4; l++) r[l] = bus.lane_ready_o[l];
        return r;
    endfunction

    task automatic drive();
        for (int l = 0; l < 4; l++) begin
            bus.lane_valid_i[l] = q[l].size() > 0 && !hold[l];
            bus.lane_data_i[l]  = '0;
            bus.lane_last_i[l]  = 1'b0;
            if (q[l].size() > 0) begin
                bus.lane_data_i[l] = q[l][0][63:0];
                bus.lane_last_i[l] = q[l][0][64];
            end
        end
    endtask

    // Handshakes are sampled at the falling edge; FIFO pops apply just after the rising edge.
    task automatic tick();
        logic pop [4];
        @(negedge clk_i);
        for (int l = 0; l < 4; l++) pop[l] = bus.lane_valid_i[l] && bus.lane_ready_o[l];
        if (bus.out_valid_o && bus.out_ready_i) begin
            log_data.push_back(bus.out_data_o);
            log_last.push_back(bus.out_last_o);
            log_lane.push_back(int'(bus.out_lane_o));
            log_cyc.push_back(cyc);
        end
        @(posedge clk_i);
        #1;
        cyc++;
        for (int l = 0; l < 4; l++) if (pop[l]) void'(q[l].pop_front());
        drive();
    endtask

    task automatic load(input int l, input int n, input logic [63:0] base);
        for (int b = 0; b < n; b++) q[l].push_back({b == n - 1, base + 64'(b)});
        drive();
    endtask

    task automatic clear_all();
        for (int l = 0; l < 4; l++) begin
            q[l].delete();
            hold[l] = 1'b0;
        end
        log_data.delete();
        log_last.delete();
        log_lane.delete();
        log_cyc.delete();
        drive();
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        clear_all();
        repeat (2) tick();
        rst_i = 1'b0;
    endtask

    task automatic run_until(input int n, input int budget);
        int k = 0;
        while (log_data.size() < n && k < budget) begin
            tick();
            k++;
        end
        check("run_count", 64'(log_data.size()), 64'(n));
    endtask

    task automatic wait_out(input logic [63:0] d);
        int k = 0;
        while (!(bus.out_valid_o && bus.out_data_o == d) && k < 20) begin
            tick();
            k++;
        end
        check("reach_beat", 64'(k < 20), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        bus.out_ready_i = 1'b1;
        clear_all();
        repeat (2) tick();
        check("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
        check("rst_out_data", bus.out_data_o, 64'd0);
        check("rst_out_last", 64'(bus.out_last_o), 64'd0);
        check("rst_out_lane", 64'(bus.out_lane_o), 64'd0);
        check("rst_ready", 64'(rdy()), 64'd0);
        check("rst_err", 64'(bus.err_o), 64'd0);
        rst_i = 1'b0;

        // Single lane, 3-beat packet, back-to-back beats
        load(2, 3, 64'hA20);
        check("t1_idle_ready", 64'(rdy()), 64'd0);
        tick();
        check("t1_grant_ready", 64'(rdy()), 64'b0100);
        run_until(3, 20);
        for (int b = 0; b < 3 && b < log_data.size(); b++) begin
            check("t1_lane", 64'(log_lane[b]), 64'd2);
            check("t1_data", log_data[b], 64'hA20 + 64'(b));
            check("t1_last", 64'(log_last[b]), 64'(b == 2));
            check("t1_gap", 64'(log_cyc[b] - log_cyc[0]), 64'(b));
        end

        // All lanes hold 1-beat packets: order 0..3, two cycles apart, then wrap to 0
        do_reset();
        for (int l = 0; l < 4; l++) load(l, 1, 64'hB00 + 64'(l * 16));
        run_until(4, 40);
        for (int b = 0; b < 4 && b < log_data.size(); b++) begin
            check("t2_lane", 64'(log_lane[b]), 64'(b));
            check("t2_data", log_data[b], 64'hB00 + 64'(b * 16));
            check("t2_last", 64'(log_last[b]), 64'd1);
            if (b > 0) check("t2_gap", 64'(log_cyc[b] - log_cyc[b-1]), 64'd2);
        end
        load(0, 1, 64'hB50);
        run_until(5, 20);
        if (log_data.size() == 5) begin
            check("t2_wrap_lane", 64'(log_lane[4]), 64'd0);
            check("t2_wrap_data", log_data[4], 64'hB50);
        end

        // Downstream stall on beat 2 of a 4-beat lane 1 packet
        do_reset();
        load(1, 4, 64'hC10);
        wait_out(64'hC11);
        bus.out_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t3_hold_data", bus.out_data_o, 64'hC11);
            check("t3_hold_valid", 64'(bus.out_valid_o), 64'd1);
            check("t3_hold_ready", 64'(rdy()), 64'd0);
        end
        bus.out_ready_i = 1'b1;
        run_until(4, 20);
        for (int b = 0; b < 4 && b < log_data.size(); b++) begin
            check("t3_data", log_data[b], 64'hC10 + 64'(b));
            check("t3_last", 64'(log_last[b]), 64'(b == 3));
        end

        // Granted lane 0 stalls mid-packet while lane 3 waits
        do_reset();
        load(0, 4, 64'hD00);
        load(3, 1, 64'hD30);
        tick();
        tick();
        hold[0] = 1'b1;
        drive();
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t4_stall_ready", 64'(rdy()), 64'b0001);
        end
        hold[0] = 1'b0;
        drive();
        run_until(5, 30);
        for (int b = 0; b < 5 && b < log_data.size(); b++) begin
            check("t4_lane", 64'(log_lane[b]), b < 4 ? 64'd0 : 64'd3);
            check("t4_data", log_data[b], b < 4 ? 64'hD00 + 64'(b) : 64'hD30);
        end

        // Asynchronous reset during beat 2 of 5 on lane 2
        do_reset();
        load(2, 5, 64'hE20);
        wait_out(64'hE21);
        load(0, 1, 64'hE00);
        check("t5_other_lane_ignored", 64'(rdy()), 64'b0100);
        #2;
        rst_i = 1'b1;
        #1;
        check("t5_async_valid", 64'(bus.out_valid_o), 64'd0);
        check("t5_async_ready", 64'(rdy()), 64'd0);
        check("t5_async_data", bus.out_data_o, 64'd0);
        check("t5_remainder", 64'(q[2].size()), 64'd3);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        log_data.delete();
        log_last.delete();
        log_lane.delete();
        log_cyc.delete();
        tick();
        check("t5_regrant", 64'(rdy()), 64'b0001);
        run_until(1, 10);
        if (log_data.size() >= 1) begin
            check("t5_lane", 64'(log_lane[0]), 64'd0);
            check("t5_data", log_data[0], 64'hE00);
        end

        // 6-beat packet against the length limit
        do_reset();
        load(0, 6, 64'hF00);
        run_until(6, 40);
        for (int b = 0; b < 6 && b < log_data.size(); b++) begin
            check("t6_lane", 64'(log_lane[b]), 64'd0);
            check("t6_data", log_data[b], 64'hF00 + 64'(b));
`ifdef PACKET_BUFFER_READ_ARB_LEN_CHECK_EN
            check("t6_last", 64'(log_last[b]), 64'(b == 3 || b == 5));
`else
            check("t6_last", 64'(log_last[b]), 64'(b == 5));
`endif
        end
        repeat (3) tick();
`ifdef PACKET_BUFFER_READ_ARB_LEN_CHECK_EN
        check("t6_err_sticky", 64'(bus.err_o), 64'd1);
`else
        check("t6_err", 64'(bus.err_o), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
